// File: rtl/relu_maxpool.sv
// 2x2 stride-2 max pooling with optional ReLU over one registered tile, streamed out one word per cycle.
// Build option: define RELU_MAXPOOL_RELU_EN to clamp negative pooled values to zero.
module relu_maxpool #(
  parameter int DATA_W = 16,
  parameter int IN_DIM = 8,
  localparam int CW = $clog2((IN_DIM / 2) * (IN_DIM / 2))
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [IN_DIM*IN_DIM-1:0][DATA_W-1:0]   pixels_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_W-1:0]                      out_data,
  output logic [CW-1:0]                          out_index,
  output logic                                   out_last
);

  localparam int OUT_DIM = IN_DIM / 2;
  localparam int N_OUT   = OUT_DIM * OUT_DIM;
  localparam int AW      = $clog2(IN_DIM * IN_DIM);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state;
  state_t state_nxt;

  logic [IN_DIM*IN_DIM-1:0][DATA_W-1:0] tile;
  logic [CW-1:0] cnt;

  logic take;
  logic fire;
  logic at_last;

  logic [CW-1:0]     pr;
  logic [CW-1:0]     pc;
  logic [AW-1:0]     base;
  logic [DATA_W-1:0] w00;
  logic [DATA_W-1:0] w01;
  logic [DATA_W-1:0] w10;
  logic [DATA_W-1:0] w11;
  logic [DATA_W-1:0] pmax;
  logic [DATA_W-1:0] pooled;

  function automatic logic [DATA_W-1:0] smax(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign take    = in_valid && in_ready;
  assign fire    = out_valid && out_ready;
  assign at_last = (cnt == CW'(N_OUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = EMIT;
      EMIT:    if (fire && at_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                cnt <= '0;
    else if (take)            cnt <= '0;
    else if (fire && at_last) cnt <= '0;
    else if (fire)            cnt <= cnt + CW'(1);
  end

  // Held untouched during EMIT so the streamed words stay consistent.
  always_ff @(posedge clk) begin
    if (take) tile <= pixels_in;
  end

  always_comb begin
    pr   = cnt / CW'(OUT_DIM);
    pc   = cnt % CW'(OUT_DIM);
    base = AW'(pr) * AW'(2 * IN_DIM) + AW'(pc) * AW'(2);
    w00  = tile[base];
    w01  = tile[base + AW'(1)];
    w10  = tile[base + AW'(IN_DIM)];
    w11  = tile[base + AW'(IN_DIM + 1)];
    pmax = smax(smax(w00, w01), smax(w10, w11));
`ifdef RELU_MAXPOOL_RELU_EN
    pooled = pmax[DATA_W-1] ? '0 : pmax;
`else
    pooled = pmax;
`endif
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !reset;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_data  = pooled;
        out_index = cnt;
        out_last  = at_last;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: queue-based pooling model plus literal checks.
module tb_relu_maxpool;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset     = 1'b1;
  logic                 in_valid  = 1'b0;
  logic                 in_ready;
  logic [63:0][15:0]    pixels_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [15:0]          out_data;
  logic [3:0]           out_index;
  logic                 out_last;

  relu_maxpool dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pixels_in (pixels_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  i;
    logic        l;
  } exp_t;

  exp_t        q[$];
  logic [15:0] seen[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          armed = 1'b0;

  int ramp_exp [16] = '{9, 11, 13, 15, 25, 27, 29, 31,
                        41, 43, 45, 47, 57, 59, 61, 63};

  logic [63:0][15:0] ramp;
  logic [63:0][15:0] neg1;
  logic [63:0][15:0] ext;
  logic [63:0][15:0] hund;
  logic [15:0]       neg_exp;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_seen(input string nm, input int k,
                          input logic [15:0] e);
    logic [31:0] a;
    a = (k < seen.size()) ? {16'h0, seen[k]} : 32'hxxxx_xxxx;
    chk($sformatf("%s_%0d", nm, k), a, {16'h0, e});
  endtask

  // Pooling from the definition: max over the 2x2 window, then ReLU.
  function automatic logic [15:0] ref_pool(input logic [63:0][15:0] t,
                                           input int k);
    int pr, pc, best, v;
    pr   = k / 4;
    pc   = k % 4;
    best = -32768;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        v = $signed(t[(2 * pr + dr) * 8 + 2 * pc + dc]);
        if (v > best) best = v;
      end
`ifdef RELU_MAXPOOL_RELU_EN
    if (best < 0) best = 0;
`endif
    return best[15:0];
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", {31'h0, in_ready},
          {31'h0, (!reset && q.size() == 0)});
      chk("out_valid", {31'h0, out_valid}, {31'h0, q.size() != 0});
      if (q.size() != 0) begin
        chk("out_data", {16'h0, out_data}, {16'h0, q[0].d});
        chk("out_index", {28'h0, out_index}, {28'h0, q[0].i});
        chk("out_last", {31'h0, out_last}, {31'h0, q[0].l});
      end
      if (reset) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) begin
          seen.push_back(out_data);
          void'(q.pop_front());
        end
        if (in_valid && q.size() == 0 && in_ready)
          for (int k = 0; k < 16; k++)
            q.push_back('{ref_pool(pixels_in, k), k[3:0], k == 15});
      end
    end
  end

  task automatic send_tile(input logic [63:0][15:0] t);
    int n;
    n = 0;
    pixels_in = t;
    in_valid  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    chk("accept_wait", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_seen(input int n);
    int c;
    c = 0;
    while (seen.size() < n && c < 500) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("seen_wait", {31'h0, seen.size() >= n}, 32'h1);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (q.size() != 0 && c < 1000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_wait", q.size(), 32'h0);
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      ramp[k] = k[15:0];
      neg1[k] = 16'hFFFF;
      ext[k]  = 16'h0000;
      hund[k] = 16'd100;
    end
    ext[0]  = 16'h8000;
    ext[1]  = 16'h7FFF;
    ext[8]  = 16'h0000;
    ext[9]  = 16'hFFFB;
    ext[2]  = 16'hFFFD;
    ext[3]  = 16'hFFF9;
    ext[10] = 16'hFFFF;
    ext[11] = 16'hFFFE;
`ifdef RELU_MAXPOOL_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hFFFF;
`endif

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_last", {31'h0, out_last}, 32'h0);
    chk("rst_out_index", {28'h0, out_index}, 32'h0);
    chk("rst_out_data", {16'h0, out_data}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    armed = 1'b1;
    reset = 1'b0;

    chk("model_ramp0", {16'h0, ref_pool(ramp, 0)}, 32'd9);
    chk("model_ext0", {16'h0, ref_pool(ext, 0)}, 32'h7FFF);
    chk("model_ext1", {16'h0, ref_pool(ext, 1)}, {16'h0, neg_exp});

    seen.delete();
    send_tile(ramp);
    wait_idle();
    chk("ramp_count", seen.size(), 32'd16);
    for (int k = 0; k < 16; k++) chk_seen("ramp", k, ramp_exp[k][15:0]);

    seen.delete();
    send_tile(neg1);
    wait_idle();
    for (int k = 0; k < 16; k++) chk_seen("neg1", k, neg_exp);

    seen.delete();
    send_tile(ext);
    wait_idle();
    chk_seen("ext", 0, 16'h7FFF);
    chk_seen("ext", 1, neg_exp);
    chk_seen("ext", 2, 16'h0000);

    seen.delete();
    send_tile(ramp);
    wait_seen(3);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_data", {16'h0, out_data}, 32'd15);
      chk("bp_index", {28'h0, out_index}, 32'd3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    chk("bp_count", seen.size(), 32'd16);
    for (int k = 0; k < 16; k++) chk_seen("bp", k, ramp_exp[k][15:0]);

    seen.delete();
    send_tile(ramp);
    send_tile(hund);
    wait_idle();
    chk("busy_count", seen.size(), 32'd32);
    for (int k = 0; k < 16; k++) chk_seen("busy_a", k, ramp_exp[k][15:0]);
    for (int k = 16; k < 32; k++) chk_seen("busy_b", k, 16'd100);

    seen.delete();
    send_tile(ramp);
    wait_seen(5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    seen.delete();
    send_tile(ramp);
    @(negedge clk);
    chk("restart_index", {28'h0, out_index}, 32'h0);
    @(posedge clk);
    #1;
    wait_idle();
    chk("restart_count", seen.size(), 32'd16);
    chk_seen("restart", 0, 16'd9);
    chk_seen("restart", 15, 16'd63);

    chk("final_queue", q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/relu_maxpool.md
# relu_maxpool

Downstream stage of the 8×8 convolution block. It accepts one 64-word convolved, bias-subtracted tile per handshake and applies 2×2 stride-2 max pooling with ReLU. It then streams the 16 pooled words out one per cycle under valid/ready flow control. It decouples the parallel convolution output from the serial next layer / Avalon-facing logic in the CNN Qsys system.

## Interface
Parameters:
- DATA_W, 16, pixel width; two's-complement signed.
- IN_DIM, 8, input tile edge; must be even. The output tile edge is IN_DIM/2. Defaults are the only verified configuration.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  pixels_in holds a complete tile.
- in_ready  out  1  block can capture a tile.
- pixels_in  in  [63:0][15:0]  input tile; word r*8+c = row r, column c (the convolution's pixels_out layout).
- out_valid  out  1  out_data/out_index valid.
- out_ready  in  1  downstream accepts the current word.
- out_data  out  16  pooled value.
- out_index  out  4  pooled position pr*4+pc.
- out_last  out  1  high with index 15.

## Operation
- FSM states: IDLE and EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, register all 64 words into tile buffer, clear cnt (4-bit), go to EMIT.
- EMIT:
  - in_ready=0, out_valid=1, out_index=cnt, out_last=(cnt==15).
  - out_data = pool(cnt), computed only from tile buffer and cnt registers. There is no combinational path from pixels_in or out_ready to any output.
- pool(k):
  - pr=k[3:2], pc=k[1:0].
  - Signed max of words (2pr)*8+2pc, (2pr)*8+2pc+1, (2pr+1)*8+2pc, (2pr+1)*8+2pc+1.
  - Then ReLU: result<0 → 0, else result.
  - All comparisons are signed 16-bit; no widening, no saturation needed.
- Handshake:
  - On out_valid&&out_ready, cnt increments.
  - If cnt==15 at that handshake, return to IDLE; cnt wraps to 0.
  - While out_ready=0, out_data, out_index and out_last are held stable.
- in_valid is ignored in EMIT. The tile buffer is not overwritten until the block returns to IDLE.
- Reset (any state, including mid-EMIT):
  - Next state IDLE, cnt=0, in-flight tile discarded.
  - Tile buffer need not be cleared.

## Timing
- Reset values: out_valid=0, out_last=0, out_index=0, out_data=0.
- in_ready=0 while reset is high; in_ready=1 the first cycle after reset deasserts.
- Latency: first out_valid in the cycle after the accepting edge.
- Throughput with out_ready held high: 16 output cycles + 1 IDLE cycle = one tile per 17 cycles.
- in_ready rises the cycle after the out_last handshake. Tile capture and the final output are never in the same cycle.
- A simultaneous reset and handshake resolves to reset.

## Configuration
- RELU_MAXPOOL_RELU_EN:
  - Defined: ReLU applied after pooling, as described above.
  - Undefined: ReLU stage is omitted; out_data is the raw signed 2×2 max, and negative values pass through.
  - All other behaviour and timing are identical in both builds.

## Test plan
- Ramp tile, pixels_in[k]=k, out_ready=1 → outputs 9,11,13,15,25,27,29,31,41,43,45,47,57,59,61,63 on consecutive cycles. Indices run 0..15, out_last only on the 16th, in_ready high one cycle later.
- All words 16'hFFFF (−1) → sixteen 16'h0000 with RELU_MAXPOOL_RELU_EN; sixteen 16'hFFFF without.
- Signed extremes:
  - Window {−32768, 32767, 0, −5} → 32767.
  - Window {−3,−7,−1,−2} → 0 with the macro, 16'hFFFF without.
- Backpressure:
  - Ramp tile, out_ready low during outputs 3–7 → out_data=15, out_index=3 held stable throughout.
  - Sequence then completes with no lost or duplicated words.
- Busy rejection: in_valid held high with a second tile (all 100) during EMIT → in_ready=0 and the first tile's outputs are unchanged. The second tile is accepted the cycle after out_last; 16 outputs of 100 follow.
- Reset after 5 outputs → out_valid=0 next cycle, then in_ready=1. A new tile restarts at out_index=0.
